// File: rtl/ex_operand_stage_if.sv
// ID -> EX bundle: decoded fields and control bits from ID, plus the
// load-use hold request flowing back to ID/IF.
interface ex_operand_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          valid;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic [15:0]   imm16;
   logic [RW-1:0] rs;
   logic [RW-1:0] rt;
   logic [RW-1:0] rd;
   logic [5:0]    funct;
   logic [1:0]    aluop;
   logic          alusrc;
   logic          regdst;
   logic          regwrite;
   logic          memread;
   logic          memwrite;
   logic          memtoreg;
   logic          branch;
   logic          load_use_stall;

   modport master (
      output valid, rs_data, rt_data, imm16, rs, rt, rd, funct, aluop,
             alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch,
      input  load_use_stall
   );

   modport slave (
      input  valid, rs_data, rt_data, imm16, rs, rt, rd, funct, aluop,
             alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch,
      output load_use_stall
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and MEM/WB
// operand forwarding, and load-use hazard detection.
module ex_operand_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   ex_operand_stage_if.slave id,
   input  logic          stall_i,
   input  logic          flush_i,
   input  logic          exmem_regwrite_i,
   input  logic [RW-1:0] exmem_rd_i,
   input  logic [DW-1:0] exmem_result_i,
   input  logic          memwb_regwrite_i,
   input  logic [RW-1:0] memwb_rd_i,
   input  logic [DW-1:0] memwb_data_i,
   output logic          ex_valid_o,
   output logic [DW-1:0] alu_a_o,
   output logic [DW-1:0] alu_b_o,
   output logic [2:0]    alu_signal_o,
   output logic [DW-1:0] ex_rt_fwd_o,
   output logic [DW-1:0] ex_imm_ext_o,
   output logic [RW-1:0] ex_dest_o,
   output logic          ex_regwrite_o,
   output logic          ex_memread_o,
   output logic          ex_memwrite_o,
   output logic          ex_memtoreg_o,
   output logic          ex_branch_o,
   output logic          ex_illegal_o
);

   localparam logic [2:0] SIG_AND = 3'b000;
   localparam logic [2:0] SIG_OR  = 3'b001;
   localparam logic [2:0] SIG_ADD = 3'b010;
   localparam logic [2:0] SIG_SUB = 3'b110;
   localparam logic [2:0] SIG_SLT = 3'b111;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm_ext;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] dest;
      logic          alusrc;
      logic          regwrite;
      logic          memread;
      logic          memwrite;
      logic          memtoreg;
      logic          branch;
      logic          illegal;
      logic [2:0]    sig;
   } ex_reg_t;

   ex_reg_t ex_q, ex_d;

   logic [2:0] dec_sig;
   logic       dec_illegal;
   logic       lus;
   logic [DW-1:0] fwd_rs, fwd_rt;

   // A bubble is an all-zero entry except the ALU signal, which idles at add.
   function automatic ex_reg_t bubble();
      ex_reg_t b;
      b     = '0;
      b.sig = SIG_ADD;
      return b;
   endfunction

   // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] r,
      input logic [DW-1:0] rf,
      input logic          em_we,
      input logic [RW-1:0] em_rd,
      input logic [DW-1:0] em_res,
      input logic          mw_we,
      input logic [RW-1:0] mw_rd,
      input logic [DW-1:0] mw_dat
   );
      if (em_we && em_rd == r && r != '0)      return em_res;
      else if (mw_we && mw_rd == r && r != '0) return mw_dat;
      else                                     return rf;
   endfunction

   // ALU control decode of the instruction currently in ID.
   always_comb begin
      dec_sig     = SIG_ADD;
      dec_illegal = 1'b0;
      unique case (id.aluop)
         2'b00: dec_sig = SIG_ADD;
         2'b01: dec_sig = SIG_SUB;
         2'b10: begin
            unique case (id.funct)
               6'h20:   dec_sig = SIG_ADD;
               6'h22:   dec_sig = SIG_SUB;
               6'h24:   dec_sig = SIG_AND;
               6'h25:   dec_sig = SIG_OR;
               6'h2A:   dec_sig = SIG_SLT;
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Load in EX whose destination is read by the instruction in ID.
   assign lus = ex_q.valid & ex_q.memread & (ex_q.dest != '0) & id.valid &
                ((ex_q.dest == id.rs) | ((ex_q.dest == id.rt) & ~id.alusrc));
   assign id.load_use_stall = lus;

   // Next-state selection: flush > stall > load-use bubble > load from ID.
   always_comb begin
      ex_d = ex_q;
      if (flush_i) begin
         ex_d = bubble();
      end else if (stall_i) begin
         ex_d = ex_q;
      end else if (lus || !id.valid) begin
         ex_d = bubble();
      end else begin
         ex_d.valid    = 1'b1;
         ex_d.rs_data  = id.rs_data;
         ex_d.rt_data  = id.rt_data;
         ex_d.imm_ext  = {{(DW-16){id.imm16[15]}}, id.imm16};
         ex_d.rs       = id.rs;
         ex_d.rt       = id.rt;
         ex_d.dest     = id.regdst ? id.rd : id.rt;
         ex_d.alusrc   = id.alusrc;
         ex_d.regwrite = id.regwrite & ~dec_illegal;
         ex_d.memread  = id.memread;
         ex_d.memwrite = id.memwrite;
         ex_d.memtoreg = id.memtoreg;
         ex_d.branch   = id.branch;
         ex_d.illegal  = dec_illegal;
         ex_d.sig      = dec_sig;
      end
   end

   // ID/EX register; reset leaves a bubble.
   always_ff @(posedge clk) begin
      if (rst) ex_q <= bubble();
      else     ex_q <= ex_d;
   end

   // Operand forwarding from the later pipeline stages.
   always_comb begin
      fwd_rs = fwd(ex_q.rs, ex_q.rs_data, exmem_regwrite_i, exmem_rd_i,
                   exmem_result_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i);
      fwd_rt = fwd(ex_q.rt, ex_q.rt_data, exmem_regwrite_i, exmem_rd_i,
                   exmem_result_i, memwb_regwrite_i, memwb_rd_i, memwb_data_i);
   end

   assign alu_a_o       = fwd_rs;
   assign alu_b_o       = ex_q.alusrc ? ex_q.imm_ext : fwd_rt;
   assign ex_rt_fwd_o   = fwd_rt;
   assign alu_signal_o  = ex_q.sig;
   assign ex_imm_ext_o  = ex_q.imm_ext;
   assign ex_dest_o     = ex_q.dest;
   assign ex_valid_o    = ex_q.valid;
   assign ex_regwrite_o = ex_q.regwrite;
   assign ex_memread_o  = ex_q.memread;
   assign ex_memwrite_o = ex_q.memwrite;
   assign ex_memtoreg_o = ex_q.memtoreg;
   assign ex_branch_o   = ex_q.branch;
   assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;
   localparam int DW = 32;
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst;
   logic stall, flush;
   logic          em_we, mw_we;
   logic [RW-1:0] em_rd, mw_rd;
   logic [DW-1:0] em_res, mw_dat;
   logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite;
   logic          ex_memtoreg, ex_branch, ex_illegal;
   logic [DW-1:0] alu_a, alu_b, ex_rt_fwd, ex_imm_ext;
   logic [2:0]    alu_signal;
   logic [RW-1:0] ex_dest;

   int ncmp = 0;
   int nerr = 0;

   ex_operand_stage_if #(.DW(DW), .RW(RW)) ifc ();

   ex_operand_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .id(ifc),
      .stall_i(stall), .flush_i(flush),
      .exmem_regwrite_i(em_we), .exmem_rd_i(em_rd), .exmem_result_i(em_res),
      .memwb_regwrite_i(mw_we), .memwb_rd_i(mw_rd), .memwb_data_i(mw_dat),
      .ex_valid_o(ex_valid), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_signal_o(alu_signal), .ex_rt_fwd_o(ex_rt_fwd),
      .ex_imm_ext_o(ex_imm_ext), .ex_dest_o(ex_dest),
      .ex_regwrite_o(ex_regwrite), .ex_memread_o(ex_memread),
      .ex_memwrite_o(ex_memwrite), .ex_memtoreg_o(ex_memtoreg),
      .ex_branch_o(ex_branch), .ex_illegal_o(ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_id();
      ifc.valid = 0; ifc.rs_data = 0; ifc.rt_data = 0; ifc.imm16 = 0;
      ifc.rs = 0; ifc.rt = 0; ifc.rd = 0; ifc.funct = 0; ifc.aluop = 0;
      ifc.alusrc = 0; ifc.regdst = 0; ifc.regwrite = 0; ifc.memread = 0;
      ifc.memwrite = 0; ifc.memtoreg = 0; ifc.branch = 0;
   endtask

   task automatic rtype(input logic [5:0] f, input logic [4:0] rs, rt, rd,
                        input logic [31:0] a, b);
      clr_id();
      ifc.valid = 1; ifc.aluop = 2'b10; ifc.funct = f; ifc.regdst = 1;
      ifc.regwrite = 1; ifc.rs = rs; ifc.rt = rt; ifc.rd = rd;
      ifc.rs_data = a; ifc.rt_data = b;
   endtask

   task automatic lw(input logic [4:0] rs, rt);
      clr_id();
      ifc.valid = 1; ifc.aluop = 2'b00; ifc.alusrc = 1; ifc.memread = 1;
      ifc.memtoreg = 1; ifc.regwrite = 1; ifc.rs = rs; ifc.rt = rt;
      ifc.imm16 = 16'h0004;
   endtask

   logic [5:0] fn_tab [3];
   logic [2:0] sg_tab [3];

   initial begin
      fn_tab[0] = 6'h24; sg_tab[0] = 3'b000;
      fn_tab[1] = 6'h25; sg_tab[1] = 3'b001;
      fn_tab[2] = 6'h2A; sg_tab[2] = 3'b111;

      rst = 1; stall = 0; flush = 0;
      em_we = 0; em_rd = 0; em_res = 0; mw_we = 0; mw_rd = 0; mw_dat = 0;
      clr_id();
      step(); step();
      chk("rst_valid", ex_valid, 0);
      chk("rst_sig", alu_signal, 3'b010);
      chk("rst_ctrl", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                       ex_branch, ex_illegal}, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_dest", ex_dest, 0);
      chk("rst_lus", ifc.load_use_stall, 0);

      // R-type sub
      rst = 0;
      rtype(6'h22, 5'd1, 5'd2, 5'd3, 32'd7, 32'd3);
      step();
      chk("sub_a", alu_a, 7);
      chk("sub_b", alu_b, 3);
      chk("sub_sig", alu_signal, 3'b110);
      chk("sub_dest", ex_dest, 3);
      chk("sub_valid", ex_valid, 1);
      chk("sub_rw", ex_regwrite, 1);

      // Immediate add with negative immediate
      clr_id();
      ifc.valid = 1; ifc.alusrc = 1; ifc.imm16 = 16'hFFFC; ifc.rs = 4;
      ifc.rs_data = 32'd10; ifc.rt = 9; ifc.rt_data = 32'h99; ifc.regwrite = 1;
      step();
      chk("imm_ext", ex_imm_ext, 32'hFFFF_FFFC);
      chk("imm_b", alu_b, 32'hFFFF_FFFC);
      chk("imm_sig", alu_signal, 3'b010);
      chk("imm_dest", ex_dest, 9);
      chk("imm_rtfwd", ex_rt_fwd, 32'h99);

      // Forwarding
      clr_id();
      ifc.valid = 1; ifc.rs = 5; ifc.rs_data = 32'h55; ifc.rt = 6;
      ifc.rt_data = 32'h66;
      step();
      em_we = 1; em_rd = 5; em_res = 32'h11;
      mw_we = 1; mw_rd = 5; mw_dat = 32'h22;
      #1;
      chk("fwd_exmem", alu_a, 32'h11);
      chk("fwd_b_none", alu_b, 32'h66);
      em_we = 0;
      #1;
      chk("fwd_memwb", alu_a, 32'h22);
      mw_rd = 6;
      #1;
      chk("fwd_rt", ex_rt_fwd, 32'h22);
      chk("fwd_rt_b", alu_b, 32'h22);
      chk("fwd_rs_rf", alu_a, 32'h55);
      clr_id();
      ifc.valid = 1; ifc.rs = 0; ifc.rs_data = 32'h77;
      em_we = 1; em_rd = 0; mw_we = 1; mw_rd = 0;
      step();
      chk("fwd_r0", alu_a, 32'h77);
      em_we = 0; em_rd = 0; em_res = 0; mw_we = 0; mw_rd = 0; mw_dat = 0;

      // Load-use
      lw(5'd1, 5'd8);
      step();
      chk("lw_memread", ex_memread, 1);
      rtype(6'h20, 5'd8, 5'd2, 5'd10, 32'h1, 32'h2);
      #1;
      chk("lu_stall", ifc.load_use_stall, 1);
      step();
      chk("lu_bubble", ex_valid, 0);
      chk("lu_release", ifc.load_use_stall, 0);
      chk("lu_mr", ex_memread, 0);
      step();
      chk("lu_add_valid", ex_valid, 1);
      chk("lu_add_dest", ex_dest, 10);

      // Stall alone holds
      rtype(6'h22, 5'd3, 5'd4, 5'd11, 32'h5, 32'h6);
      stall = 1;
      step();
      chk("stall_dest", ex_dest, 10);
      chk("stall_sig", alu_signal, 3'b010);
      chk("stall_valid", ex_valid, 1);
      chk("stall_a", alu_a, 32'h1);

      // Stall + flush -> bubble
      flush = 1;
      step();
      chk("sf_valid", ex_valid, 0);
      chk("sf_dest", ex_dest, 0);
      chk("sf_rw", ex_regwrite, 0);
      stall = 0; flush = 0;

      // Illegal funct and reserved aluop
      rtype(6'h03, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2);
      step();
      chk("ill_flag", ex_illegal, 1);
      chk("ill_rw", ex_regwrite, 0);
      chk("ill_sig", alu_signal, 3'b010);
      chk("ill_valid", ex_valid, 1);
      rtype(6'h20, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2);
      ifc.aluop = 2'b11;
      step();
      chk("ill11_flag", ex_illegal, 1);
      chk("ill11_rw", ex_regwrite, 0);

      // Remaining R-type decodes
      for (int i = 0; i < 3; i++) begin
         rtype(fn_tab[i], 5'd1, 5'd2, 5'd13, 32'h1, 32'h2);
         step();
         chk($sformatf("dec_%0h", fn_tab[i]), alu_signal, sg_tab[i]);
         chk($sformatf("dec_ill_%0h", fn_tab[i]), ex_illegal, 0);
      end
      clr_id();
      ifc.valid = 1; ifc.aluop = 2'b01; ifc.branch = 1;
      step();
      chk("beq_sig", alu_signal, 3'b110);
      chk("beq_br", ex_branch, 1);

      // id_valid low loads a bubble
      rtype(6'h22, 5'd1, 5'd2, 5'd14, 32'h1, 32'h2);
      ifc.valid = 0;
      step();
      chk("idinv_valid", ex_valid, 0);
      chk("idinv_sig", alu_signal, 3'b010);

      // Stall during load-use holds, then reset mid-stall clears
      lw(5'd1, 5'd8);
      step();
      rtype(6'h20, 5'd2, 5'd8, 5'd10, 32'h1, 32'h2);
      stall = 1;
      #1;
      chk("slu_stall0", ifc.load_use_stall, 1);
      step();
      chk("slu_hold_mr", ex_memread, 1);
      chk("slu_stall1", ifc.load_use_stall, 1);
      rst = 1;
      step();
      chk("mid_rst_valid", ex_valid, 0);
      chk("mid_rst_lus", ifc.load_use_stall, 0);
      rst = 0; stall = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
